flp_operand_queue: RTL and testbench
====================================

// Module: flp_operand_queue
// PURPOSE
// Upstream issue stage of the FLP adder pipeline. Buffers operand pairs {A,B} in a
// DEPTH-entry FIFO with valid/ready handshakes on both sides. On write it orders each
// pair by magnitude (larger |x| on out_a) and classifies each operand. The adder's
// align/add stages consume the head entry without re-deriving special cases.
// PARAMETERS
// DEPTH   4   entry count; power of two, >=2. Pointer width AW=$clog2(DEPTH) (localparam)
// PORTS
// clk          in   1      rising-edge clock
// rst_n        in   1      asynchronous active-low reset
// flush        in   1      synchronous clear of all entries; wins over push/pop
// in_valid     in   1      producer offers in_a/in_b
// in_ready     out  1      queue can accept (count<DEPTH)
// in_a         in   32     IEEE-754 single operand A
// in_b         in   32     IEEE-754 single operand B
// out_valid    out  1      head entry present (count!=0)
// out_ready    in   1      consumer takes head entry
// out_a        out  32     larger-magnitude operand of head pair
// out_b        out  32     smaller-or-equal-magnitude operand of head pair
// out_swapped  out  1      1: head pair was stored as {in_b,in_a}
// out_cls_a    out  3      class of out_a: 0 normal,1 zero,2 denorm,3 inf,4 nan
// out_cls_b    out  3      class of out_b, same encoding
// count        out  AW+1   number of valid entries, 0..DEPTH
// BEHAVIOUR
// - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, all storage cleared to 0.
//   Outputs: in_ready=1, out_valid=0, out_a=out_b=0, out_swapped=0, cls=1 (zero), count=0.
// - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated per cycle.
// - Outputs are a combinational read of entry[rd_ptr]; no fall-through. An entry pushed in
//   cycle N is visible on out_* with out_valid=1 in cycle N+1 (latency 1).
// - Swap rule: compare bits[30:0] unsigned. If in_b[30:0] > in_a[30:0], store
//   {in_b,in_a} and set swapped=1. Otherwise, including equal magnitudes, store
//   {in_a,in_b} with swapped=0. Sign bits travel with their operand.
// - Class, from exponent e=[30:23] and fraction f=[22:0]:
//   e=0 & f=0 zero; e=0 & f!=0 denorm; e=255 & f=0 inf; e=255 & f!=0 nan; else normal.
//   Class is computed on write and stored per entry.
// - Pointers advance by 1 on push/pop and wrap from DEPTH-1 to 0.
// - count: +1 on push only, -1 on pop only, unchanged on push&pop or on neither.
// - Full (count=DEPTH): in_ready=0; in_valid is ignored, and in_a/in_b are not written.
//   A pop while full frees a slot, but in_ready stays combinational from count, so the next
//   push is accepted in the following cycle.
// - Empty (count=0): out_valid=0; out_ready is ignored, and pointers/count hold.
// - Simultaneous push and pop with 0<count<DEPTH: both complete and count holds.
// - flush=1: next edge sets wr_ptr=rd_ptr=count=0. A concurrent push or pop is discarded.
//   Storage contents are not cleared.
// - Reset asserted mid-operation: all queued pairs are dropped immediately. The first push
//   after rst_n deasserts lands in entry 0.
// TESTING
// - Reset: hold rst_n=0 -> in_ready=1, out_valid=0, count=0, out_a=0, out_cls_a=1.
// - Latency/swap: push A=0x3F800000, B=0xC0000000 -> next cycle out_valid=1,
//   out_a=0xC0000000, out_b=0x3F800000, out_swapped=1, cls_a=0, cls_b=0.
// - Full (DEPTH=4): push 4 pairs with out_ready=0 -> count=4, in_ready=0. A 5th in_valid
//   leaves count=4; popping 4 returns the pairs in push order.
// - Concurrent push/pop with wrap: at count=2, push&pop together for 6 cycles -> count stays
//   2, pointers wrap, output order preserved.
// - Classes: push A=0x7FC00000, B=0x00000001 -> out_a=0x7FC00000 cls_a=4, cls_b=2,
//   swapped=0. Push A=B=0x7F800000 -> cls=3/3, swapped=0.
// - Flush/reset: with count=3, assert flush together with push -> count=0, out_valid=0
//   next cycle. Repeat with async rst_n pulse mid-cycle -> immediate clear.

Source files
------------

// File: rtl/flp_operand_queue.sv
// flp_operand_queue: issue-stage FIFO for the FLP adder. Each operand pair is
// ordered by magnitude and classified as it is written, so the align/add
// stages read a ready-to-use head entry without re-deriving special cases.
module flp_operand_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_a,
  output logic [31:0]                out_b,
  output logic                       out_swapped,
  output logic [2:0]                 out_cls_a,
  output logic [2:0]                 out_cls_b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [2:0] CLS_NORMAL = 3'd0;
  localparam logic [2:0] CLS_ZERO   = 3'd1;
  localparam logic [2:0] CLS_DENORM = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_NAN    = 3'd4;

  // Operand class from the biased exponent and fraction fields.
  function automatic logic [2:0] classify(input logic [31:0] x);
    logic [2:0] c;
    c = CLS_NORMAL;
    if (x[30:23] == 8'h00) begin
      c = (x[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
    end else if (x[30:23] == 8'hFF) begin
      c = (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
    return c;
  endfunction

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic [31:0] a_mem   [DEPTH];
  logic [31:0] b_mem   [DEPTH];
  logic        sw_mem  [DEPTH];
  logic [2:0]  cla_mem [DEPTH];
  logic [2:0]  clb_mem [DEPTH];

  logic        push;
  logic        pop;
  logic        wr_swap;
  logic [31:0] wr_a;
  logic [31:0] wr_b;

  // Handshake qualification and write-side ordering; equal magnitudes keep A first.
  always_comb begin
    in_ready  = (count_reg != CNT_FULL);
    out_valid = (count_reg != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_swap   = (in_b[30:0] > in_a[30:0]);
    wr_a      = wr_swap ? in_b : in_a;
    wr_b      = wr_swap ? in_a : in_b;
  end

  // Entry storage: a flush discards the concurrent push but leaves contents intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem[i]   <= '0;
        b_mem[i]   <= '0;
        sw_mem[i]  <= 1'b0;
        cla_mem[i] <= CLS_ZERO;
        clb_mem[i] <= CLS_ZERO;
      end
    end else if (push && !flush) begin
      a_mem[wr_ptr_reg]   <= wr_a;
      b_mem[wr_ptr_reg]   <= wr_b;
      sw_mem[wr_ptr_reg]  <= wr_swap;
      cla_mem[wr_ptr_reg] <= classify(wr_a);
      clb_mem[wr_ptr_reg] <= classify(wr_b);
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      count_reg <= count_reg + CNT_ONE;
      else if (pop && !push) count_reg <= count_reg - CNT_ONE;
    end
  end

  // Head entry is a plain combinational read; no fall-through from the input.
  always_comb begin
    out_a       = a_mem[rd_ptr_reg];
    out_b       = b_mem[rd_ptr_reg];
    out_swapped = sw_mem[rd_ptr_reg];
    out_cls_a   = cla_mem[rd_ptr_reg];
    out_cls_b   = clb_mem[rd_ptr_reg];
    count       = count_reg;
  end

endmodule

// File: tb/tb_flp_operand_queue.sv
// tb_flp_operand_queue: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the operand FIFO.
module tb_flp_operand_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_swapped;
  logic [2:0]  out_cls_a;
  logic [2:0]  out_cls_b;
  logic [2:0]  count;

  flp_operand_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_swapped(out_swapped),
    .out_cls_a(out_cls_a), .out_cls_b(out_cls_b), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sw;
    logic [2:0]  ca;
    logic [2:0]  cb;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  function automatic logic [2:0] cls_of(input logic [31:0] x);
    int e;
    int f;
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    if (e == 0)   return (f == 0) ? 3'd1 : 3'd2;
    if (e == 255) return (f == 0) ? 3'd3 : 3'd4;
    return 3'd0;
  endfunction

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] b);
    ent_t t;
    if (b[30:0] > a[30:0]) begin
      t.a = b; t.b = a; t.sw = 1'b1;
    end else begin
      t.a = a; t.b = b; t.sw = 1'b0;
    end
    t.ca = cls_of(t.a);
    t.cb = cls_of(t.b);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy decided from the model's own size, not the DUT's.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() != 0);
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) begin
          $display("pop  a=%h b=%h sw=%0d cls=%0d/%0d", q[0].a, q[0].b, q[0].sw, q[0].ca, q[0].cb);
          void'(q.pop_front());
        end
        if (do_push) q.push_back(mk(in_a, in_b));
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      if (q.size() != 0) begin
        chk("out_a", out_a, q[0].a);
        chk("out_b", out_b, q[0].b);
        chk("out_swapped", 32'(out_swapped), 32'(q[0].sw));
        chk("out_cls_a", 32'(out_cls_a), 32'(q[0].ca));
        chk("out_cls_b", 32'(out_cls_b), 32'(q[0].cb));
      end
    end
  end

  // Inputs change 2 time units after a rising edge and are sampled at the next one.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic f);
    @(posedge clk);
    #2;
    in_valid = v; in_a = a; in_b = b; out_ready = r; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:23] = 8'h00;
      1: x[30:23] = 8'hFF;
      2: x[30:0]  = 31'h0;
      3: begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst out_a", out_a, 32'h0);
    chk("rst out_cls_a", 32'(out_cls_a), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Latency and swap
    drive(1'b1, 32'h3F800000, 32'hC0000000, 1'b0, 1'b0);
    idle(); #4;
    chk("lat out_valid", 32'(out_valid), 32'd1);
    chk("lat out_a", out_a, 32'hC0000000);
    chk("lat out_b", out_b, 32'h3F800000);
    chk("lat swapped", 32'(out_swapped), 32'd1);
    chk("lat cls", {26'd0, out_cls_a, out_cls_b}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Classes: NaN vs denorm, then inf vs inf pushed while popping
    drive(1'b1, 32'h7FC00000, 32'h00000001, 1'b0, 1'b0);
    idle(); #4;
    chk("nan out_a", out_a, 32'h7FC00000);
    chk("nan cls_a", 32'(out_cls_a), 32'd4);
    chk("den cls_b", 32'(out_cls_b), 32'd2);
    chk("nan swapped", 32'(out_swapped), 32'd0);
    drive(1'b1, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0);
    idle(); #4;
    chk("inf count", 32'(count), 32'd1);
    chk("inf cls", {26'd0, out_cls_a, out_cls_b}, {26'd0, 3'd3, 3'd3});
    chk("inf swapped", 32'(out_swapped), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Full: four pushes, a fifth offer ignored, then drain in order
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h40000000 + i, 32'h3F000000 + i, 1'b0, 1'b0);
    idle(); #4;
    chk("full count", 32'(count), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full head", out_a, 32'h40000000);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(); #4;
    chk("drain count", 32'(count), 32'd0);

    // Concurrent push/pop at count=2 across pointer wrap
    for (int i = 0; i < 2; i++) drive(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, rand_op(), rand_op(), 1'b1, 1'b0);
    idle(); #4;
    chk("wrap count", 32'(count), 32'd2);
    for (int i = 0; i < 2; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) drive(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    drive(1'b1, 32'h12345678, 32'h0, 1'b1, 1'b1);
    idle(); #4;
    chk("flush count", 32'(count), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) drive(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    idle();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst count", 32'(count), 32'd0);
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst out_a", out_a, 32'h0);
    #3 rst_n = 1'b1;
    drive(1'b1, 32'h41200000, 32'h40A00000, 1'b0, 1'b0);
    idle(); #4;
    chk("post-rst head", out_a, 32'h41200000);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = rand_op();
      rb = ($urandom_range(0, 7) == 0) ? {~ra[31], ra[30:0]} : rand_op();
      drive(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(); #4;
    chk("final count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
